// File: rtl/mvme_4ch_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency Q8.27 4-channel MAC datapath
// among NUM_REQ requesters, with per-requester credit limits and sticky overload.
module mvme_4ch_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 10,
  parameter int MAX_OUT = 4,
  parameter int W       = 35,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW     = $clog2(MAX_OUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*8*W-1:0]   req_opnd,
  output logic [8*W-1:0]           dp_opnd,
  input  logic [W-1:0]             dp_total,
  input  logic [W-1:0]             dp_ab_cd,
  input  logic [W-1:0]             dp_ef_gh,
  input  logic                     dp_overload,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [W-1:0]             rsp_total,
  output logic [W-1:0]             rsp_ab_cd,
  output logic [W-1:0]             rsp_ef_gh,
  output logic                     rsp_overload,
  output logic [NUM_REQ-1:0]       ovl_sticky,
  input  logic [NUM_REQ-1:0]       ovl_clr,
  output logic                     idle
);

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     gnt_id;
  logic [IDW:0]       cand_sum;
  logic [IDW-1:0]     cand;
  logic               accept;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] inc_v;
  logic [NUM_REQ-1:0] dec_v;
  logic [NUM_REQ-1:0] set_v;
  logic [NUM_REQ-1:0] cnt_nz;
  logic [CW-1:0]      out_cnt [NUM_REQ];

  // Stage 0 is loaded together with dp_opnd; stage LATENCY lines up with dp_*.
  logic [LATENCY:0]   tag_v;
  logic [IDW-1:0]     tag_id [LATENCY+1];

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = rst_n & enable & req_valid[i] & (out_cnt[i] < CW'(MAX_OUT));
    end
  end

  always_comb begin
    grant    = '0;
    gnt_id   = '0;
    accept   = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NUM_REQ)) cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
      cand = cand_sum[IDW-1:0];
      if (!accept && elig[cand]) begin
        accept      = 1'b1;
        grant[cand] = 1'b1;
        gnt_id      = cand;
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    inc_v  = '0;
    dec_v  = '0;
    set_v  = '0;
    cnt_nz = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc_v[i]  = accept && (gnt_id == IDW'(i));
      dec_v[i]  = rsp_valid && (rsp_id == IDW'(i));
      set_v[i]  = dec_v[i] && rsp_overload;
      cnt_nz[i] = |out_cnt[i];
    end
  end

  assign idle = ~(|tag_v) & ~(|cnt_nz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= IDW'(NUM_REQ - 1);
      dp_opnd <= '0;
      tag_v   <= '0;
      for (int unsigned k = 0; k <= LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[LATENCY-1:0], accept};
      tag_id[0] <= gnt_id;
      for (int unsigned k = 1; k <= LATENCY; k++) tag_id[k] <= tag_id[k-1];
      if (accept) begin
        rr_ptr  <= gnt_id;
        dp_opnd <= req_opnd[gnt_id*8*W +: 8*W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_total    <= '0;
      rsp_ab_cd    <= '0;
      rsp_ef_gh    <= '0;
      rsp_overload <= 1'b0;
    end else begin
      rsp_valid <= tag_v[LATENCY];
      rsp_id    <= tag_id[LATENCY];
      if (tag_v[LATENCY]) begin
        rsp_total    <= dp_total;
        rsp_ab_cd    <= dp_ab_cd;
        rsp_ef_gh    <= dp_ef_gh;
        rsp_overload <= dp_overload;
      end
    end
  end

  // Retires act on the registered count, so a freed slot is grantable one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovl_sticky <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) out_cnt[i] <= '0;
    end else begin
      ovl_sticky <= set_v | (ovl_sticky & ~ovl_clr);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (inc_v[i] && !dec_v[i])      out_cnt[i] <= out_cnt[i] + CW'(1);
        else if (dec_v[i] && !inc_v[i]) out_cnt[i] <= out_cnt[i] - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mvme_4ch_rr_sched.sv
// Directed bench for mvme_4ch_rr_sched with a behavioural Q8.27 MAC datapath stub.
module tb_mvme_4ch_rr_sched;
  localparam int NR  = 4;
  localparam int LAT = 10;
  localparam int W   = 35;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*8*W-1:0] req_opnd;
  logic [8*W-1:0]    dp_opnd;
  logic [W-1:0]      dp_total, dp_ab_cd, dp_ef_gh;
  logic              dp_overload;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_total, rsp_ab_cd, rsp_ef_gh;
  logic              rsp_overload;
  logic [NR-1:0]     ovl_sticky;
  logic [NR-1:0]     ovl_clr;
  logic              idle;

  int n_chk  = 0;
  int n_pass = 0;

  mvme_4ch_rr_sched #(.NUM_REQ(NR), .LATENCY(LAT), .MAX_OUT(4), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_opnd(req_opnd),
    .dp_opnd(dp_opnd), .dp_total(dp_total), .dp_ab_cd(dp_ab_cd),
    .dp_ef_gh(dp_ef_gh), .dp_overload(dp_overload),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_total(rsp_total),
    .rsp_ab_cd(rsp_ab_cd), .rsp_ef_gh(rsp_ef_gh), .rsp_overload(rsp_overload),
    .ovl_sticky(ovl_sticky), .ovl_clr(ovl_clr), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stub: Q8.27 products, pair sums and total, LAT register stages, never reset.
  logic signed [W-1:0]     op [8];
  logic signed [2*W+1:0]   s_ab, s_ef, s_t;
  logic                    s_ov;
  logic [W-1:0]            pt [LAT];
  logic [W-1:0]            pab [LAT];
  logic [W-1:0]            pef [LAT];
  logic                    pov [LAT];

  function automatic logic ovf(input logic [2*W+1:0] x);
    return !((&x[2*W+1:W-1]) || (~|x[2*W+1:W-1]));
  endfunction

  always_comb begin
    for (int k = 0; k < 8; k++) op[k] = dp_opnd[k*W +: W];
    s_ab = ((op[0] * op[1]) >>> 27) + ((op[2] * op[3]) >>> 27);
    s_ef = ((op[4] * op[5]) >>> 27) + ((op[6] * op[7]) >>> 27);
    s_t  = s_ab + s_ef;
    s_ov = ovf(s_ab) | ovf(s_ef) | ovf(s_t);
  end

  always @(posedge clk) begin
    pt[0]  <= s_t[W-1:0];
    pab[0] <= s_ab[W-1:0];
    pef[0] <= s_ef[W-1:0];
    pov[0] <= s_ov;
    for (int k = 1; k < LAT; k++) begin
      pt[k]  <= pt[k-1];
      pab[k] <= pab[k-1];
      pef[k] <= pef[k-1];
      pov[k] <= pov[k-1];
    end
  end

  assign dp_total    = pt[LAT-1];
  assign dp_ab_cd    = pab[LAT-1];
  assign dp_ef_gh    = pef[LAT-1];
  assign dp_overload = pov[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_op(input int r, input logic [W-1:0] v);
    for (int k = 0; k < 8; k++) req_opnd[(r*8+k)*W +: W] = v;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rsp_seen", 64'(rsp_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!idle && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drained_idle", 64'(idle), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int npulse;
    int exp_g [8];
    logic exp_r;
    exp_g = '{3, 0, 1, 2, 3, 0, 1, 2};

    rst_n = 1'b1; enable = 1'b0; req_valid = '0; req_opnd = '0; ovl_clr = '0;
    #3 rst_n = 1'b0;

    // Reset held with random inputs
    repeat (3) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      ovl_clr   = 4'($urandom);
      enable    = 1'b1;
      #1;
    end
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_sticky", 64'(ovl_sticky), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);

    @(negedge clk);
    rst_n = 1'b1; ovl_clr = '0; req_valid = 4'b1010;
    #1;
    chk("first_grant", 64'(req_ready), 64'b0010);
    req_valid = '0;

    // Single op on requester 2, all operands 1.0
    @(negedge clk);
    set_op(2, 35'h0800_0000);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single_ready_off", 64'(req_ready), 64'd0);
    chk("single_busy", 64'(idle), 64'd0);
    wait_rsp(n);
    chk("single_latency", 64'(n), 64'd11);
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_total", 64'(rsp_total), 64'h2000_0000);
    chk("single_ab_cd", 64'(rsp_ab_cd), 64'h1000_0000);
    chk("single_ef_gh", 64'(rsp_ef_gh), 64'h1000_0000);
    chk("single_ovl", 64'(rsp_overload), 64'd0);
    @(negedge clk); #1;
    chk("single_pulse", 64'(rsp_valid), 64'd0);
    chk("single_idle", 64'(idle), 64'd1);

    // Fairness: pointer left at 2, so order starts at 3
    for (int r = 0; r < NR; r++) set_op(r, 35'(r + 1) << 27);
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
      chk("rr_grant", 64'(req_ready), 64'(1 << exp_g[s]));
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_rsp(n);
    for (int s = 0; s < 8; s++) begin
      if (s > 0) begin
        @(negedge clk); #1;
      end
      chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rr_rsp_id", 64'(rsp_id), 64'(exp_g[s]));
    end
    @(negedge clk); #1;
    chk("rr_rsp_end", 64'(rsp_valid), 64'd0);
    wait_idle();

    // Credit limit on requester 0
    for (int s = 1; s <= 18; s++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      exp_r = ((s >= 1 && s <= 4) || (s >= 14 && s <= 17)) ? 1'b1 : 1'b0;
      chk("credit_ready", 64'(req_ready), 64'(exp_r));
      if (s == 12) chk("credit_no_rsp", 64'(rsp_valid), 64'd0);
      if (s == 13) chk("credit_first_rsp", 64'(rsp_valid), 64'd1);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_idle();

    // enable low mid-stream; pointer at 0
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      req_valid = 4'b1111; enable = 1'b1;
      #1;
      chk("en_grant", 64'(req_ready), 64'(2 << s));
    end
    npulse = 0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      enable = 1'b0;
      #1;
      chk("en_off_ready", 64'(req_ready), 64'd0);
      if (rsp_valid) npulse++;
    end
    @(negedge clk);
    req_valid = '0; enable = 1'b1;
    #1;
    if (rsp_valid) npulse++;
    n = 0;
    while (!idle && n < 40) begin
      @(negedge clk); #1;
      n++;
      if (rsp_valid) npulse++;
    end
    chk("en_drain_count", 64'(npulse), 64'd3);
    chk("en_idle", 64'(idle), 64'd1);

    // Overload on requester 1: 100.0 * 100.0
    set_op(1, 35'h3_2000_0000);
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("ovl_ready", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_rsp(n);
    chk("ovl_id", 64'(rsp_id), 64'd1);
    chk("ovl_flag", 64'(rsp_overload), 64'd1);
    @(negedge clk); #1;
    chk("ovl_sticky_set", 64'(ovl_sticky), 64'b0010);

    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_rsp(n);
    ovl_clr = 4'b0010;
    @(negedge clk);
    ovl_clr = '0;
    #1;
    chk("ovl_set_wins", 64'(ovl_sticky), 64'b0010);
    @(negedge clk);
    ovl_clr = 4'b0010;
    @(negedge clk);
    ovl_clr = '0;
    #1;
    chk("ovl_cleared", 64'(ovl_sticky), 64'd0);
    wait_idle();

    // Reset with 5 ops in flight
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
    end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midrst_idle", 64'(idle), 64'd1);
    chk("midrst_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    repeat (25) begin
      @(negedge clk); #1;
      if (rsp_valid) npulse++;
    end
    chk("midrst_no_rsp", 64'(npulse), 64'd0);
    chk("midrst_idle_after", 64'(idle), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
